// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller in front of the ALU: decodes ARM data-processing
// opcodes into ALU controls, waits the ALU settle time, then captures result and NZCV.
module alu_exec_ctrl #(
  parameter int ALU_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  opcode,
  input  logic        s_bit,
  input  logic [3:0]  rd,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        invert_a,
  output logic        invert_b,
  output logic        is_logic,
  output logic        cin,
  output logic        isactive,
  output logic [2:0]  logic_func_idx,
  input  logic [31:0] alu_result,
  input  logic        alu_c,
  output logic        wb_valid,
  input  logic        out_ready,
  output logic        wb_we,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [3:0]  nzcv
);

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_e;

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic          invert_a_q, invert_a_d, invert_b_q, invert_b_d;
  logic          is_logic_q, is_logic_d, cin_q, cin_d, isactive_q, isactive_d;
  logic [2:0]    func_idx_q, func_idx_d;
  logic          wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic [3:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [3:0]    nzcv_q, nzcv_d;
  logic          we_pend_q, we_pend_d, flag_en_q, flag_en_d;
  logic [3:0]    rd_pend_q, rd_pend_d;

  logic          dec_inv_a, dec_inv_b, dec_cin, dec_logic, dec_we;
  logic [2:0]    dec_idx;
  logic          accept;
  logic          res_n, res_z, a_sign, b_sign, res_v;
  logic [3:0]    new_nzcv;

  // Opcode decode; carry-using ops take C from the flags as they stand at accept.
  always_comb begin
    dec_inv_a = 1'b0;
    dec_inv_b = 1'b0;
    dec_cin   = 1'b0;
    dec_logic = 1'b0;
    dec_idx   = 3'd0;
    dec_we    = 1'b1;
    case (opcode)
      4'h0: begin dec_logic = 1'b1; dec_idx = 3'd0; end
      4'h1: begin dec_logic = 1'b1; dec_idx = 3'd2; end
      4'h2: begin dec_inv_b = 1'b1; dec_cin = 1'b1; end
      4'h3: begin dec_inv_a = 1'b1; dec_cin = 1'b1; end
      4'h4: ;
      4'h5: dec_cin = nzcv_q[1];
      4'h6: begin dec_inv_b = 1'b1; dec_cin = nzcv_q[1]; end
      4'h7: begin dec_inv_a = 1'b1; dec_cin = nzcv_q[1]; end
      4'h8: begin dec_logic = 1'b1; dec_idx = 3'd0; dec_we = 1'b0; end
      4'h9: begin dec_logic = 1'b1; dec_idx = 3'd2; dec_we = 1'b0; end
      4'hA: begin dec_inv_b = 1'b1; dec_cin = 1'b1; dec_we = 1'b0; end
      4'hB: dec_we = 1'b0;
      4'hC: begin dec_logic = 1'b1; dec_idx = 3'd1; end
      4'hD: begin dec_logic = 1'b1; dec_idx = 3'd3; end
      4'hE: begin dec_logic = 1'b1; dec_idx = 3'd0; dec_inv_b = 1'b1; end
      default: begin dec_logic = 1'b1; dec_idx = 3'd3; dec_inv_b = 1'b1; end
    endcase
  end

  // Flags use the post-inversion operand signs for overflow.
  always_comb begin
    res_n    = alu_result[31];
    res_z    = (alu_result == 32'd0);
    a_sign   = alu_a_q[31] ^ invert_a_q;
    b_sign   = alu_b_q[31] ^ invert_b_q;
    res_v    = (a_sign == b_sign) && (res_n != a_sign);
    new_nzcv = is_logic_q ? {res_n, res_z, nzcv_q[1:0]} : {res_n, res_z, alu_c, res_v};
  end

  assign accept = (state_q == IDLE) && in_valid && !flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    invert_a_d = invert_a_q;
    invert_b_d = invert_b_q;
    is_logic_d = is_logic_q;
    cin_d      = cin_q;
    isactive_d = isactive_q;
    func_idx_d = func_idx_q;
    wb_valid_d = wb_valid_q;
    wb_we_d    = wb_we_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    nzcv_d     = nzcv_q;
    we_pend_d  = we_pend_q;
    flag_en_d  = flag_en_q;
    rd_pend_d  = rd_pend_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_a_d    = op_a;
          alu_b_d    = op_b;
          invert_a_d = dec_inv_a;
          invert_b_d = dec_inv_b;
          is_logic_d = dec_logic;
          cin_d      = dec_cin;
          func_idx_d = dec_idx;
          isactive_d = 1'b1;
          cnt_d      = CNT_INIT;
          we_pend_d  = dec_we;
          rd_pend_d  = rd;
          flag_en_d  = s_bit || (opcode[3:2] == 2'b10);
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (flush) begin
          isactive_d = 1'b0;
          state_d    = IDLE;
        end else if (cnt_q == '0) begin
          wb_data_d  = alu_result;
          wb_we_d    = we_pend_q;
          wb_rd_d    = rd_pend_q;
          if (flag_en_q) nzcv_d = new_nzcv;
          isactive_d = 1'b0;
          wb_valid_d = 1'b1;
          state_d    = WB;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WB: begin
        if (flush || out_ready) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      invert_a_q <= 1'b0;
      invert_b_q <= 1'b0;
      is_logic_q <= 1'b0;
      cin_q      <= 1'b0;
      isactive_q <= 1'b0;
      func_idx_q <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      nzcv_q     <= '0;
      we_pend_q  <= 1'b0;
      flag_en_q  <= 1'b0;
      rd_pend_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      invert_a_q <= invert_a_d;
      invert_b_q <= invert_b_d;
      is_logic_q <= is_logic_d;
      cin_q      <= cin_d;
      isactive_q <= isactive_d;
      func_idx_q <= func_idx_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      nzcv_q     <= nzcv_d;
      we_pend_q  <= we_pend_d;
      flag_en_q  <= flag_en_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign invert_a       = invert_a_q;
  assign invert_b       = invert_b_q;
  assign is_logic       = is_logic_q;
  assign cin            = cin_q;
  assign isactive       = isactive_q;
  assign logic_func_idx = func_idx_q;
  assign wb_valid       = wb_valid_q;
  assign wb_we          = wb_we_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign nzcv           = nzcv_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed self-checking bench for alu_exec_ctrl; the ALU is replaced by
// hand-computed result/carry values driven alongside each operation.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  opcode;
  logic        s_bit;
  logic [3:0]  rd;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic [31:0] alu_a, alu_b;
  logic        invert_a, invert_b, is_logic, cin, isactive;
  logic [2:0]  logic_func_idx;
  logic [31:0] alu_result;
  logic        alu_c;
  logic        wb_valid, out_ready, wb_we;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  nzcv;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.ALU_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .s_bit(s_bit), .rd(rd), .op_a(op_a), .op_b(op_b),
    .flush(flush), .alu_a(alu_a), .alu_b(alu_b), .invert_a(invert_a),
    .invert_b(invert_b), .is_logic(is_logic), .cin(cin), .isactive(isactive),
    .logic_func_idx(logic_func_idx), .alu_result(alu_result), .alu_c(alu_c),
    .wb_valid(wb_valid), .out_ready(out_ready), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .nzcv(nzcv)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Drives one op at a negedge, accepts it at the next posedge and checks the controls.
  task automatic applyStimulus(input logic [3:0] op, input logic s, input logic [3:0] dst,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic c,
                               input logic [2:0] expInv, input logic expLogic,
                               input logic [2:0] expIdx);
    @(negedge clk);
    checkOutput("in_ready before accept", 32'(in_ready), 32'd1);
    opcode = op; s_bit = s; rd = dst; op_a = a; op_b = b;
    alu_result = res; alu_c = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("isactive after accept", 32'(isactive), 32'd1);
    checkOutput("alu_a", alu_a, a);
    checkOutput("alu_b", alu_b, b);
    checkOutput("invert_a", 32'(invert_a), 32'(expInv[2]));
    checkOutput("invert_b", 32'(invert_b), 32'(expInv[1]));
    checkOutput("is_logic", 32'(is_logic), 32'(expLogic));
    if (expLogic) checkOutput("logic_func_idx", 32'(logic_func_idx), 32'(expIdx));
    else          checkOutput("cin", 32'(cin), 32'(expInv[0]));
  endtask

  // Follows the op to its capture edge T+4 and checks the write-back beat.
  task automatic waitCapture(input logic expWe, input logic [3:0] expRd,
                             input logic [31:0] expData, input logic [3:0] expNzcv);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("wb_valid low at T+3", 32'(wb_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("wb_valid at T+4", 32'(wb_valid), 32'd1);
    checkOutput("isactive dropped", 32'(isactive), 32'd0);
    checkOutput("wb_we", 32'(wb_we), 32'(expWe));
    checkOutput("wb_rd", 32'(wb_rd), 32'(expRd));
    checkOutput("wb_data", wb_data, expData);
    checkOutput("nzcv", 32'(nzcv), 32'(expNzcv));
  endtask

  task automatic finishWb();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("wb_valid after handshake", 32'(wb_valid), 32'd0);
    checkOutput("in_ready after handshake", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; opcode = 4'h0; s_bit = 1'b0; rd = 4'h0;
    op_a = '0; op_b = '0; flush = 1'b0; alu_result = '0; alu_c = 1'b0; out_ready = 1'b0;
    #12;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset nzcv", 32'(nzcv), 32'd0);
    checkOutput("reset wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("reset wb_data", wb_data, 32'd0);
    checkOutput("reset isactive", 32'(isactive), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD S=1 overflow into the sign bit
    applyStimulus(4'h4, 1'b1, 4'd3, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 3'b000, 1'b0, 3'd0);
    waitCapture(1'b1, 4'd3, 32'h80000000, 4'b1001);
    finishWb();
    // CMP without S still updates flags and does not write
    applyStimulus(4'hA, 1'b0, 4'd1, 32'd5, 32'd5, 32'd0, 1'b1, 3'b011, 1'b0, 3'd0);
    waitCapture(1'b0, 4'd1, 32'd0, 4'b0110);
    finishWb();
    // ADC picks up C=1 from the CMP
    applyStimulus(4'h5, 1'b0, 4'd2, 32'd1, 32'd2, 32'd4, 1'b0, 3'b001, 1'b0, 3'd0);
    waitCapture(1'b1, 4'd2, 32'd4, 4'b0110);
    finishWb();
    applyStimulus(4'h5, 1'b1, 4'd2, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, 3'b001, 1'b0, 3'd0);
    waitCapture(1'b1, 4'd2, 32'd0, 4'b0110);
    finishWb();
    // SUB with signed overflow leaves nzcv = 0011
    applyStimulus(4'h2, 1'b1, 4'd4, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 3'b011, 1'b0, 3'd0);
    waitCapture(1'b1, 4'd4, 32'h7FFFFFFF, 4'b0011);
    finishWb();
    // BIC keeps C and V
    applyStimulus(4'hE, 1'b1, 4'd5, 32'hFF, 32'h0F, 32'hF0, 1'b0, 3'b010, 1'b1, 3'd0);
    waitCapture(1'b1, 4'd5, 32'hF0, 4'b0011);
    finishWb();
    // MVN without S leaves flags alone
    applyStimulus(4'hF, 1'b0, 4'd6, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 3'b010, 1'b1, 3'd3);
    waitCapture(1'b1, 4'd6, 32'hFFFFFFFF, 4'b0011);
    finishWb();
    // EOR S=1 with zero result
    applyStimulus(4'h1, 1'b1, 4'd7, 32'd5, 32'd5, 32'd0, 1'b0, 3'b000, 1'b1, 3'd2);
    waitCapture(1'b1, 4'd7, 32'd0, 4'b0111);
    finishWb();
    // RSB: 3 - 1
    applyStimulus(4'h3, 1'b1, 4'd8, 32'd1, 32'd3, 32'd2, 1'b1, 3'b101, 1'b0, 3'd0);
    waitCapture(1'b1, 4'd8, 32'd2, 4'b0010);
    finishWb();

    // ORR, then hold the beat under backpressure while a new op is offered
    applyStimulus(4'hC, 1'b0, 4'd9, 32'h10, 32'h20, 32'h30, 1'b0, 3'b000, 1'b1, 3'd1);
    waitCapture(1'b1, 4'd9, 32'h30, 4'b0010);
    @(negedge clk);
    opcode = 4'h4; op_a = 32'd99; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("bp wb_valid", 32'(wb_valid), 32'd1);
      checkOutput("bp wb_data", wb_data, 32'h30);
      checkOutput("bp wb_rd", 32'(wb_rd), 32'd9);
      checkOutput("bp in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    finishWb();
    @(posedge clk); #1;
    checkOutput("bp op ignored", 32'(isactive), 32'd0);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; opcode = 4'h4;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checkOutput("idle flush blocks accept", 32'(isactive), 32'd0);
    checkOutput("idle flush in_ready", 32'(in_ready), 32'd1);

    // flush at T+2 during SUB S=1
    applyStimulus(4'h2, 1'b1, 4'd10, 32'd4, 32'd4, 32'd0, 1'b1, 3'b011, 1'b0, 3'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush in_ready", 32'(in_ready), 32'd1);
    checkOutput("flush isactive", 32'(isactive), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("flush wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("flush nzcv", 32'(nzcv), 32'd2);

    // flush landing on the capture edge
    applyStimulus(4'h2, 1'b1, 4'd11, 32'd4, 32'd4, 32'd0, 1'b1, 3'b011, 1'b0, 3'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("capture flush wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("capture flush nzcv", 32'(nzcv), 32'd2);
    checkOutput("capture flush in_ready", 32'(in_ready), 32'd1);

    // async reset mid-ISSUE
    applyStimulus(4'h4, 1'b1, 4'd12, 32'd7, 32'd8, 32'd15, 1'b0, 3'b000, 1'b0, 3'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst isactive", 32'(isactive), 32'd0);
    checkOutput("rst alu_a", alu_a, 32'd0);
    checkOutput("rst nzcv", 32'(nzcv), 32'd0);
    checkOutput("rst in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst wb_data", wb_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("post-rst wb_valid", 32'(wb_valid), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Multi-cycle execute-stage controller that sits directly upstream of the ALU. It accepts one decoded ARM data-processing operation per handshake and translates the 4-bit opcode into ALU control lines. It holds operands stable for a fixed ALU settle time, then captures the result into a write-back register and updates the architectural NZCV flags register. A valid/ready pair on each side provides backpressure to decode and to register write-back.

## Interface
- ALU_LAT, 4: cycles the ALU inputs are held before the result is sampled; must be >= 1.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded op available
- in_ready  out  1  controller can accept an op
- opcode  in  4  ARM DP opcode (0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, A CMP, B CMN, C ORR, D MOV, E BIC, F MVN)
- s_bit  in  1  update flags
- rd  in  4  destination register
- op_a, op_b  in  32  first operand / shifted second operand
- flush  in  1  synchronous abort of the in-flight op
- alu_a, alu_b  out  32  registered ALU operands
- invert_a, invert_b, is_logic, cin, isactive  out  1  registered ALU controls
- logic_func_idx  out  3  0 AND, 1 ORR, 2 EOR, 3 pass-B
- alu_result  in  32  ALU result
- alu_c  in  1  ALU carry-out
- wb_valid  out  1  write-back beat valid
- out_ready  in  1  write-back consumer ready
- wb_we  out  1  register write enable (0 for TST/TEQ/CMP/CMN)
- wb_rd  out  4  destination register
- wb_data  out  32  captured result
- nzcv  out  4  flags register {N,Z,C,V}

## Operation
- States: IDLE, ISSUE, WB. in_ready = (state == IDLE).
- IDLE: on in_valid && in_ready, latch op_a/op_b into alu_a/alu_b. Drive the controls below. Set isactive=1, load counter = ALU_LAT-1, go to ISSUE.
- ISSUE: hold all ALU outputs. Decrement the counter. At counter == 0, sample alu_result into wb_data. Update flags if enabled, drop isactive, assert wb_valid, go to WB.
- WB: hold wb_* until wb_valid && out_ready, then go to IDLE.
- Control mapping (inv_a, inv_b, cin; all arithmetic ops have is_logic=0):
  - ADD/CMN: 0,0,0
  - SUB/CMP: 0,1,1
  - RSB: 1,0,1
  - ADC: 0,0,C
  - SBC: 0,1,C
  - RSC: 1,0,C
- Logic mapping (is_logic=1):
  - AND/TST: idx 0
  - ORR: idx 1
  - EOR/TEQ: idx 2
  - MOV: idx 3
  - BIC: idx 0 with inv_b
  - MVN: idx 3 with inv_b
- C in the mapping is nzcv[1] at accept time.
- Flag enable = s_bit OR opcode in 8..B (compare ops always update).
- Flags are computed locally; the ALU's N/Z/V outputs are not used:
  - N = result[31].
  - Z = (result == 0).
  - Arithmetic: C = alu_c. V = (a'[31] == b'[31]) && (result[31] != a'[31]), where a'/b' are the post-inversion operands.
  - Logic: C and V keep their old values.
- flush: in ISSUE or WB, the state returns to IDLE next edge. Drop isactive and wb_valid, discard the op, and leave nzcv unchanged. If the flush hits on the capture edge, nzcv is not updated. flush in IDLE is ignored and blocks acceptance that cycle.

## Timing
- Reset (async, rst_n low): state IDLE, nzcv 0000, all ALU outputs 0, wb_valid 0, wb_we 0, wb_rd 0, wb_data 0. in_ready = 1 while in IDLE.
- Op accepted at edge T: isactive high from T. wb_data and nzcv updated and wb_valid high at edge T+ALU_LAT.
- WB lasts at least 1 cycle. Minimum issue interval is ALU_LAT+2 cycles.
- wb_* are stable while wb_valid && !out_ready.
- nzcv changes only on the capture edge. Back-to-back ADC sees the flags of the previous op.
- rst_n asserted mid-operation aborts immediately. No partial flag or write-back beat survives.

## Test plan
- ADD S=1, a=0x7FFFFFFF, b=1 -> wb_data 0x80000000, wb_we 1, nzcv 1001, wb_valid at T+4.
- CMP s_bit=0, a=5, b=5 -> wb_we 0, wb_data 0, nzcv 0110, alu controls inv_b=1 cin=1.
- ADC with nzcv C=1, a=1, b=2 -> cin 1, wb_data 4. Then ADC 0xFFFFFFFF+0 S=1 with C=1 -> wb_data 0, nzcv 0110.
- BIC S=1, a=0xFF, b=0x0F, prior nzcv 0011 -> wb_data 0xF0, nzcv 0011 (C,V preserved).
- out_ready low 3 cycles in WB -> wb_data/wb_rd stable, in_ready 0, new in_valid ignored. Handshake -> in_ready 1 next cycle.
- flush at T+2 during a SUB S=1 -> wb_valid never asserts, nzcv unchanged, in_ready 1 at T+3. rst_n pulse mid-ISSUE -> all outputs at reset values.
